mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage initiator that drives the word-addressed data memory (`MemWrite`, `MemRead`, `Addr`, `Wdata`, `Rdata`) on behalf of the pipeline's load/store instructions.
- Accepts one load or store request at a time over a valid/ready handshake.
- Converts byte addresses to word indices and checks alignment and range.
- Performs byte/halfword stores as read-modify-write.
- Returns lane-extracted, sign- or zero-extended load data with a one-cycle response pulse.
- While busy, `req_ready` is low; the pipeline uses it as the MEM-stage stall.

## Interface
- `DEPTH`, 512, number of 32-bit words in the data memory; word index must be < `DEPTH`.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  synchronous reset, active-low.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  unit can accept a request (high only in IDLE).
- `req_store`  input  1  1 = store, 0 = load.
- `req_size`  input  2  00 byte, 01 halfword, 10 word; 11 is an error.
- `req_unsigned`  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  input  32  byte address.
- `req_wdata`  input  32  store data; the low 8/16/32 bits are used according to `req_size`.
- `MemWrite`  output  1  memory write strobe.
- `MemRead`  output  1  memory read strobe.
- `Addr`  output  32  word index, equal to `{2'b00, addr[31:2]}`.
- `Wdata`  output  32  memory write data.
- `Rdata`  input  32  memory read data; valid at the end of a cycle with `MemRead` high.
- `resp_valid`  output  1  one-cycle completion pulse.
- `resp_err`  output  1  qualifies `resp_valid`: misaligned address, bad size, or out-of-range word index.
- `resp_rdata`  output  32  load result; 0 for stores and for errors.

## Operation
- **States:**
  - IDLE
  - RD: `MemRead`=1
  - WR: `MemWrite`=1
  - RESP: `resp_valid`=1
- **Accept:** a request is accepted when `req_valid & req_ready` is high at a rising edge. Address, size, flags and data are captured into internal registers. Inputs are ignored at all other times.
- **Error check at accept:**
  - halfword with `addr[0]`=1
  - word with `addr[1:0]`≠0
  - `req_size`=11
  - `addr[31:2]` ≥ `DEPTH`
  - On error: IDLE→RESP with `resp_err`=1 and `resp_rdata`=0. No memory strobe is ever asserted.
- **Transitions from IDLE on an accepted, valid request:**
  - Load: IDLE→RD→RESP.
  - Word store: IDLE→WR→RESP.
  - Byte/halfword store: IDLE→RD→WR→RESP.
- **RESP** always returns to IDLE.
- **Lanes (little-endian):**
  - Byte k = `addr[1:0]` occupies bits [8k+7:8k].
  - The halfword at `addr[1]` occupies bits [16·addr[1]+15 : 16·addr[1]].
- **Load result:** `Rdata` is captured at the end of RD. The selected lane is extended per `req_unsigned` and held on `resp_rdata` during RESP.
- **Sub-word store merge:** in WR, `Wdata` = captured `Rdata` with only the target lane replaced by the low byte/halfword of the store data. All other bits are preserved exactly.
- **Word store:** in WR, `Wdata` = captured store data.
- **Strobes:** `MemRead` and `MemWrite` are never high in the same cycle. Each is high for exactly one cycle per access.
- **Output holding:** `Addr` holds the captured word index from RD through RESP. `Addr` and `Wdata` are registered outputs.
- **`resp_rdata`:** 0 outside RESP.

## Timing
- **Reset** (`rst_n` low at an edge): state=IDLE. The following are all 0:
  - `MemWrite`, `MemRead`
  - `Addr`, `Wdata`
  - `resp_valid`, `resp_err`, `resp_rdata`
- **`req_ready` during and after reset:** low in any cycle where `rst_n` is low, then 1 from the first cycle after reset is released. A request presented with `rst_n` low is never accepted.
- **Reset mid-operation:**
  - Aborts immediately with no `resp_valid`.
  - A pending WR of a read-modify-write is never issued.
  - A RD already performed has no side effect.
- **Latency from the accept edge (cycle 0):**
  - Load: `MemRead` in cycle 1, `resp_valid` in cycle 2.
  - Word store: `MemWrite` in cycle 1, resp in cycle 2.
  - Sub-word store: read in cycle 1, write in cycle 2, resp in cycle 3.
  - Error: resp in cycle 1.
- **Back-to-back:** the next request is accepted at the earliest in the cycle after RESP, because `req_ready` is high again once state is IDLE. Throughput is at most one word access per 3 cycles.
- **Response:** there is no response backpressure; the `resp_valid` pulse is exactly one cycle.
- **Hold while busy:** `req_valid` held high while `req_ready` is low has no effect, and the request is re-evaluated in IDLE.

## Test plan
- Reset, then word store `addr`=0x10, data 0xDEADBEEF → `MemWrite` in cycle 1 with `Addr`=4 and `Wdata`=0xDEADBEEF; `resp_valid` in cycle 2 with `resp_err`=0.
- After the above, load byte `addr`=0x13, signed → `MemRead` in cycle 1 with `Addr`=4; `resp_rdata`=0xFFFFFFDE in cycle 2. Same load unsigned → 0x000000DE. Halfword load at 0x12, signed → 0xFFFFDEAD.
- Byte store 0x55 to 0x11 over 0xDEADBEEF → RD in cycle 1, WR in cycle 2 with `Wdata`=0xDEAD55EF; a subsequent word load at 0x10 returns 0xDEAD55EF.
- Misaligned halfword at 0x11, word at 0x12, size 11, and word at 0x800 (index 512) → each gives `resp_valid` and `resp_err` in cycle 1, `resp_rdata`=0, and no strobe asserted.
- Halfword store 0xABCD to 0x12, with `rst_n` pulled low during RD → no `MemWrite` ever, no `resp_valid`; the memory word is unchanged on re-read.
- Two loads presented back-to-back with `req_valid` held high → second accept occurs in the cycle after the first RESP; `req_ready` is low for exactly 2 cycles per load.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the pipeline MEM stage and mem_access_unit.
// The pipeline side is the master; the unit is the slave.
interface mem_access_unit_if;
  // Handshake: a request transfers at a rising edge where req_valid and
  // req_ready are both high; req_ready is high only while the unit is idle
  // and out of reset. Responses are a single-cycle resp_valid pulse with no
  // backpressure.
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage initiator: turns one load/store request at a time into
// word-addressed memory strobes, doing read-modify-write for sub-word stores
// and lane extraction plus sign/zero extension for loads.
module mem_access_unit #(
  parameter int unsigned DEPTH = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    pipe,
  output logic                MemWrite,
  output logic                MemRead,
  output logic [31:0]         Addr,
  output logic [31:0]         Wdata,
  input  logic [31:0]         Rdata,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_t;

  localparam logic [1:0]  SZ_BYTE  = 2'b00;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_WORD  = 2'b10;
  localparam logic [1:0]  SZ_BAD   = 2'b11;
  localparam logic [30:0] DEPTH_IX = 31'(DEPTH);

  state_t      state_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        store_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] sdata_q;

  logic [29:0] word_idx_d;
  logic        req_err_d;
  logic [31:0] load_val_d;
  logic [31:0] merge_d;

  // Pick the addressed byte/halfword out of a word and extend it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] w,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the target lane of the old word; every other bit survives.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                             input logic [31:0] sdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = old_w;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8]     = sdata[7:0];
      SZ_HALF: r[{off[1], 4'b0000} +: 16] = sdata[15:0];
      default: r = sdata;
    endcase
    return r;
  endfunction

  // Request decode: word index, error classification, and data-path helpers.
  always_comb begin
    word_idx_d = pipe.req_addr[31:2];
    req_err_d  = 1'b0;
    if (pipe.req_size == SZ_BAD)                             req_err_d = 1'b1;
    if (pipe.req_size == SZ_HALF && pipe.req_addr[0])        req_err_d = 1'b1;
    if (pipe.req_size == SZ_WORD && (|pipe.req_addr[1:0]))   req_err_d = 1'b1;
    if ({1'b0, word_idx_d} >= DEPTH_IX)                      req_err_d = 1'b1;
    load_val_d = extract_lane(Rdata, size_q, off_q, uns_q);
    merge_d    = merge_lane(Rdata, sdata_q, size_q, off_q);
  end

  // Main FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      store_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      sdata_q      <= 32'h0;
    end else begin
      // Strobes and the response are single-cycle pulses unless set below.
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      case (state_q)
        S_IDLE: begin
          // req_ready is high here, so req_valid alone means accept.
          if (pipe.req_valid) begin
            store_q <= pipe.req_store;
            size_q  <= pipe.req_size;
            uns_q   <= pipe.req_unsigned;
            off_q   <= pipe.req_addr[1:0];
            sdata_q <= pipe.req_wdata;
            if (req_err_d) begin
              // Bad requests never touch memory; report straight away.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              addr_q <= {2'b00, word_idx_d};
              if (pipe.req_store && pipe.req_size == SZ_WORD) begin
                state_q     <= S_WR;
                mem_write_q <= 1'b1;
                wdata_q     <= pipe.req_wdata;
              end else begin
                // Loads and sub-word stores both start with a read.
                state_q    <= S_RD;
                mem_read_q <= 1'b1;
              end
            end
          end
        end
        S_RD: begin
          if (store_q) begin
            state_q     <= S_WR;
            mem_write_q <= 1'b1;
            wdata_q     <= merge_d;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_val_d;
          end
        end
        S_WR: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pipe.req_ready  = (state_q == S_IDLE) && rst_n;
  assign pipe.resp_valid = resp_valid_q;
  assign pipe.resp_err   = resp_err_q;
  assign pipe.resp_rdata = resp_rdata_q;
  assign MemRead         = mem_read_q;
  assign MemWrite        = mem_write_q;
  assign Addr            = addr_q;
  assign Wdata           = wdata_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a driver issues requests and queues the
// expected responses and memory strobes; two monitors pop and compare.
module tb_mem_access_unit;
  localparam int DEPTH = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit_if bus();
  logic        MemWrite, MemRead;
  logic [31:0] Addr, Wdata, Rdata;
  logic [1:0]  dbg_state;

  mem_access_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pipe(bus),
    .MemWrite(MemWrite), .MemRead(MemRead), .Addr(Addr),
    .Wdata(Wdata), .Rdata(Rdata), .dbg_state_o(dbg_state)
  );

  // Word-addressed data memory.
  logic [31:0] mem [0:DEPTH-1];
  assign Rdata = mem[Addr[8:0]];
  always @(posedge clk) if (MemWrite) mem[Addr[8:0]] <= Wdata;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];       // {err, rdata}
  int          exp_cyc_q[$];
  logic [64:0] stb_q[$];       // {is_write, addr, wdata}
  int          stb_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  logic [32:0] r_e;
  int          r_c;
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got resp_valid at cycle %0d want none", cyc);
      end else begin
        r_e = exp_q.pop_front();
        r_c = exp_cyc_q.pop_front();
        check("resp_err", {31'b0, bus.resp_err}, {31'b0, r_e[32]});
        check("resp_rdata", bus.resp_rdata, r_e[31:0]);
        check("resp_cycle", 32'(cyc), 32'(r_c));
      end
    end else if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
      total++; bad++;
      $display("FAIL resp_idle: got rdata %h err %b want 0", bus.resp_rdata, bus.resp_err);
    end
  end

  // Memory strobe monitor.
  logic [64:0] s_e;
  int          s_c;
  always @(negedge clk) begin
    if (MemRead === 1'b1 && MemWrite === 1'b1) begin
      total++; bad++;
      $display("FAIL strobe_both: got MemRead and MemWrite high at cycle %0d want one", cyc);
    end else if (MemRead === 1'b1 || MemWrite === 1'b1) begin
      if (stb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe_unexpected: got rd=%b wr=%b at cycle %0d want none", MemRead, MemWrite, cyc);
      end else begin
        s_e = stb_q.pop_front();
        s_c = stb_cyc_q.pop_front();
        check("strobe_kind", {31'b0, MemWrite}, {31'b0, s_e[64]});
        check("strobe_addr", Addr, s_e[63:32]);
        check("strobe_cycle", 32'(cyc), 32'(s_c));
        if (s_e[64]) check("strobe_wdata", Wdata, s_e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // acc is the cycle number in which the request was accepted (cycle 0).
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input logic [31:0] exp_wd, input logic hold,
                       input logic abort, output int acc);
    int n;
    logic [31:0] idx;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout: got req_ready low for %0d cycles want high", n);
      bus.req_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
      idx = {2'b00, a[31:2]};
      if (!exp_err) begin
        if (!st) begin
          stb_q.push_back({1'b0, idx, 32'h0}); stb_cyc_q.push_back(acc + 1);
        end else if (sz == 2'b10) begin
          stb_q.push_back({1'b1, idx, exp_wd}); stb_cyc_q.push_back(acc + 1);
        end else begin
          stb_q.push_back({1'b0, idx, 32'h0}); stb_cyc_q.push_back(acc + 1);
          if (!abort) begin
            stb_q.push_back({1'b1, idx, exp_wd}); stb_cyc_q.push_back(acc + 2);
          end
        end
      end
      if (!abort) begin
        exp_q.push_back({exp_err, exp_rd});
        exp_cyc_q.push_back(acc + (exp_err ? 1 : ((st && sz != 2'b10) ? 3 : 2)));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, acc1, acc2, n;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[511] = 32'h80A1B2C3;

    // A load presented during reset must not be taken.
    bus.req_valid    = 1'b1;
    bus.req_store    = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, bus.req_ready}, 32'h0);
    check("rst_memread", {31'b0, MemRead}, 32'h0);
    check("rst_memwrite", {31'b0, MemWrite}, 32'h0);
    check("rst_addr", Addr, 32'h0);
    check("rst_wdata", Wdata, 32'h0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, bus.req_ready}, 32'h1);

    // Word store, then lane loads out of it.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, acc);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 32'h0, 1'b0, 1'b0, acc);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000DE, 32'h0, 1'b0, 1'b0, acc);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 32'h0, 1'b0, 1'b0, acc);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'h000000EF, 32'h0, 1'b0, 1'b0, acc);

    // Byte store read-modify-write; upper store-data bits must be ignored.
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345655, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0, 1'b0, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 32'h0, 1'b0, 1'b0, acc);

    // Error cases: no strobes, immediate error response.
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    issue(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, acc);

    // Last valid word index, sign-extended top byte.
    issue(1'b0, 2'b00, 1'b0, 32'h7FF, 32'h0, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0, 1'b0, acc);

    // Halfword store aborted by reset during its read.
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    rst_n = 1'b0;
    @(negedge clk);
    check("ready_in_midop_rst", {31'b0, bus.req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 32'h0, 1'b0, 1'b0, acc);

    // Halfword store to the low lane.
    issue(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234, 1'b0, 32'h0, 32'hDEAD1234, 1'b0, 1'b0, acc);

    // Back-to-back loads with req_valid held high.
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD1234, 32'h0, 1'b1, 1'b0, acc1);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, 32'h0, 1'b0, 1'b0, acc2);
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'd3);

    // Drain.
    n = 0;
    while ((exp_q.size() != 0 || stb_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("resp_queue_empty", 32'(exp_q.size()), 32'h0);
    check("strobe_queue_empty", 32'(stb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time %0t want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
